// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, encoding and control-word definitions for the SRM controller
package cpu_pkg;
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_GET_BD, S_EXEC, S_EXEC_CMP, S_PASS_B, S_WR_RD, S_ADDR, S_LD_ADDR,
    S_MEM_RD1, S_MEM_RD2, S_MEM_WR, S_LINK, S_BR, S_BR_REG, S_HALT
  } state_t;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;
  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;
  localparam logic [1:0] NSEL_R7 = 2'b11;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;
  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam logic [1:0] OP_MEM = 2'b00;
  localparam logic [1:0] OP_B   = 2'b00;
  localparam logic [1:0] OP_BX  = 2'b00;
  localparam logic [1:0] OP_BLX = 2'b10;
  localparam logic [1:0] OP_BL  = 2'b11;
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;
  typedef struct packed {
    logic [1:0] nsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic [1:0] pc_sel;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halt;
  } ctrl_t;
  // Moore control word for each state; anything not set stays 0
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_RST:       begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:       begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
      S_IF2:       begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      S_UPDATE_PC: begin c.load_pc = 1'b1; c.pc_sel = PC_INC; end
      S_WR_IMM:    begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
      S_GET_A:     begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      S_GET_B:     begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      S_GET_BD:    begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
      S_EXEC:      c.loadc = 1'b1;
      S_EXEC_CMP:  c.loads = 1'b1;
      S_PASS_B:    begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_WR_RD:     begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      S_ADDR:      begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LD_ADDR:   c.load_addr = 1'b1;
      S_MEM_RD1:   c.mem_cmd = MEM_READ;
      S_MEM_RD2:   begin c.mem_cmd = MEM_READ; c.nsel = NSEL_RD; c.vsel = VSEL_MDATA; c.write = 1'b1; end
      S_MEM_WR:    c.mem_cmd = MEM_WRITE;
      S_LINK:      begin c.nsel = NSEL_R7; c.vsel = VSEL_PC; c.write = 1'b1; end
      S_BR:        begin c.load_pc = 1'b1; c.pc_sel = PC_REL; end
      S_BR_REG:    begin c.load_pc = 1'b1; c.pc_sel = PC_REG; end
      S_HALT:      c.halt = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: evaluates a branch condition code against the Z/N/V status flags
module branch_cond
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);
  always_comb
    taken = cond == COND_AL ? 1'b1
          : cond == COND_EQ ? z
          : cond == COND_NE ? ~z
          : cond == COND_LT ? n ^ v
          : cond == COND_LE ? (n ^ v) | z
          : 1'b0;
endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch, decode, execute, memory and branch for the SRM datapath
module cpu_controller
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       Z_out,
  input  logic       N_out,
  input  logic       V_out,
  output logic [1:0] nsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic [1:0] pc_sel,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halt
);
  state_t state, state_d;
  ctrl_t ctrl;
  logic taken;
  logic mov_imm, mov_reg, mvn, alu_ab, cmp, ldr, str, br, bl, bx, blx, hlt;
  branch_cond u_branch_cond (
    .cond  (cond),
    .z     (Z_out),
    .n     (N_out),
    .v     (V_out),
    .taken (taken)
  );
  assign mov_imm = opcode == OPC_MOV && op == OP_MOV_IMM;
  assign mov_reg = opcode == OPC_MOV && op == OP_MOV_REG;
  assign mvn     = opcode == OPC_ALU && op == OP_MVN;
  assign alu_ab  = opcode == OPC_ALU && (op == OP_ADD || op == OP_AND);
  assign cmp     = opcode == OPC_ALU && op == OP_CMP;
  assign ldr     = opcode == OPC_LDR && op == OP_MEM;
  assign str     = opcode == OPC_STR && op == OP_MEM;
  assign br      = opcode == OPC_B && op == OP_B;
  assign bl      = opcode == OPC_BL && op == OP_BL;
  assign bx      = opcode == OPC_BL && op == OP_BX;
  assign blx     = opcode == OPC_BL && op == OP_BLX;
  assign hlt     = opcode == OPC_HALT;
  // IR is stable for the whole instruction, so later states may still look at opcode/op
  always_comb begin
    state_d = S_RST;
    case (state)
      S_RST:       state_d = S_IF1;
      S_IF1:       state_d = S_IF2;
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE:    state_d = mov_imm ? S_WR_IMM
                           : (mov_reg || mvn) ? S_GET_B
                           : (alu_ab || cmp || ldr || str) ? S_GET_A
                           : br ? (taken ? S_BR : S_IF1)
                           : bl ? S_LINK
                           : (bx || blx) ? S_GET_BD
                           : (hlt || HALT_ON_ILLEGAL) ? S_HALT
                           : S_IF1;
      S_GET_A:     state_d = (ldr || str) ? S_ADDR : S_GET_B;
      S_GET_B:     state_d = cmp ? S_EXEC_CMP : mov_reg ? S_PASS_B : S_EXEC;
      S_GET_BD:    state_d = S_PASS_B;
      S_EXEC:      state_d = S_WR_RD;
      S_PASS_B:    state_d = mov_reg ? S_WR_RD : str ? S_MEM_WR : blx ? S_LINK : S_BR_REG;
      S_ADDR:      state_d = S_LD_ADDR;
      S_LD_ADDR:   state_d = ldr ? S_MEM_RD1 : S_GET_BD;
      S_MEM_RD1:   state_d = S_MEM_RD2;
      S_LINK:      state_d = bl ? S_BR : S_BR_REG;
      S_HALT:      state_d = S_HALT;
      S_WR_IMM, S_WR_RD, S_EXEC_CMP, S_MEM_RD2, S_MEM_WR, S_BR, S_BR_REG:
                   state_d = S_IF1;
      default:     state_d = S_RST;
    endcase
  end
  // outputs are registered alongside the state so they stay a pure function of it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_RST;
      ctrl  <= ctrl_of(S_RST);
    end else begin
      state <= state_d;
      ctrl  <= ctrl_of(state_d);
    end
  assign {nsel, write, loada, loadb, loadc, loads, asel, bsel, vsel, load_ir,
          load_pc, reset_pc, pc_sel, load_addr, addr_sel, mem_cmd, halt} = ctrl;
endmodule
